stream_to_banded_array_loader: RTL and testbench

- Sequential successor to the flat-to-array reshaper. Accepts a ROWS×COLS frame of BIT_WIDTH elements as a stream of LANES-element beats over a valid/ready handshake.
- Scatters the beats into a registered 2-D array in either banded sub-array order or row-major order, then presents the complete frame downstream over a second valid/ready handshake.
- Sits between narrow memory/DMA read ports and array-consuming compute blocks.

---
 rtl/array_ops_pkg.sv | 23 ++
 rtl/tile_index_map.sv | 41 ++++
 rtl/stream_to_banded_array_loader.sv | 132 +++++++++++++
 tb/tb_stream_to_banded_array_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/array_ops_pkg.sv
// Shared types, mode encodings and elaboration helpers for the
// stream/array reshaping units.
package array_ops_pkg;

    localparam logic MODE_BANDED   = 1'b0;
    localparam logic MODE_ROWMAJOR = 1'b1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    function automatic int beats_f(input int rows, input int cols, input int lanes);
        return (rows * cols) / lanes;
    endfunction

    function automatic bit params_ok(input int rows, input int cols,
                                     input int sub_rows, input int lanes);
        return (lanes > 0) && (((rows * cols) % lanes) == 0) &&
               (sub_rows > 0) && (sub_rows < rows);
    endfunction

endpackage

// File: rtl/tile_index_map.sv
// Element index + mode -> (row, col) for banded or row-major layouts.
// Built as a constant lookup over every index, so no divider is inferred.
module tile_index_map
    import array_ops_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int SUB_ROWS = 4,
    parameter int IDX_W    = 6,
    parameter int ROW_W    = 3,
    parameter int COL_W    = 3
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_mode,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col
);

    localparam int R2   = ROWS - SUB_ROWS;
    localparam int TOPN = COLS * SUB_ROWS;

    always_comb begin
        o_row = '0;
        o_col = '0;
        for (int k = 0; k < ROWS * COLS; k++) begin
            if (i_idx == IDX_W'(k)) begin
                if (i_mode == MODE_ROWMAJOR) begin
                    o_row = ROW_W'(k / COLS);
                    o_col = COL_W'(k % COLS);
                end else if (k < TOPN) begin
                    o_row = ROW_W'(k % SUB_ROWS);
                    o_col = COL_W'(k / SUB_ROWS);
                end else begin
                    o_row = ROW_W'(SUB_ROWS + ((k - TOPN) % R2));
                    o_col = COL_W'((k - TOPN) / R2);
                end
            end
        end
    end

endmodule

// File: rtl/stream_to_banded_array_loader.sv
// Collects LANES-wide beats into a registered ROWS x COLS frame and
// hands the complete frame downstream over valid/ready.
module stream_to_banded_array_loader
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4,
    parameter int LANES     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [LANES*BIT_WIDTH-1:0]           in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 mode,
    input  logic                                 clear,
    output logic [BIT_WIDTH-1:0]                 out [ROWS][COLS],
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(ROWS*COLS/LANES+1)-1:0] fill_level
);

    localparam int BEATS = beats_f(ROWS, COLS, LANES);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(BEATS);

    if (!params_ok(ROWS, COLS, SUB_ROWS, LANES)) begin : g_bad_params
        $error("stream_to_banded_array_loader: illegal ROWS/COLS/SUB_ROWS/LANES");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_mode;
    logic               w_mode;
    logic               w_accept;
    logic [BIT_WIDTH-1:0] r_arr [ROWS][COLS];
    logic [IDX_W-1:0]   w_idx [LANES];
    logic [ROW_W-1:0]   w_row [LANES];
    logic [COL_W-1:0]   w_col [LANES];

    // Beat 0 maps with the live mode input; the rest of the frame uses the latch.
    assign w_mode   = (r_beat_cnt == '0) ? mode : r_mode;
    assign w_accept = in_valid && in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_idx[g] = IDX_W'(r_beat_cnt) * IDX_W'(LANES) + IDX_W'(g);

        tile_index_map #(
            .ROWS     (ROWS),
            .COLS     (COLS),
            .SUB_ROWS (SUB_ROWS),
            .IDX_W    (IDX_W),
            .ROW_W    (ROW_W),
            .COL_W    (COL_W)
        ) u_map (
            .i_idx  (w_idx[g]),
            .i_mode (w_mode),
            .o_row  (w_row[g]),
            .o_col  (w_col[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                in_ready = !clear;
                if (clear) begin
                    w_cnt_nxt = '0;
                end else if (in_valid) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt = ST_FULL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                out_valid = 1'b1;
                w_cnt_nxt = '0;
                if (clear || out_ready) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_beat_cnt <= '0;
            r_mode     <= MODE_BANDED;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            if (w_accept && (r_beat_cnt == '0)) begin
                r_mode <= mode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_arr[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int l = 0; l < LANES; l++) begin
                r_arr[w_row[l]][w_col[l]] <= in_data[l*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign out        = r_arr;
    assign fill_level = (r_state == ST_FULL) ? FULL_LVL : r_beat_cnt;

endmodule

// File: tb/tb_stream_to_banded_array_loader.sv
// Directed bench for stream_to_banded_array_loader at default parameters.
module tb_stream_to_banded_array_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic        clear;
    logic [3:0]  out [8][8];
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fill_level;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int frame;
        int row;
        int col;
        int exp;
    } cell_t;

    cell_t tbl[$];

    stream_to_banded_array_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .clear      (clear),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Beat b lane l carries (4b + l + off) mod 16; tog flips mode from beat 4 on.
    task automatic send_beats(input int first, input int n, input logic md,
                              input int off, input bit tog);
        int t;
        for (int b = first; b < first + n; b++) begin
            for (int l = 0; l < 4; l++) begin
                in_data[l*4 +: 4] = 4'((b * 4 + l + off) % 16);
            end
            in_valid = 1'b1;
            mode     = (tog && b >= 4) ? ~md : md;
            #1;
            t = 0;
            while (!in_ready && t < 20) begin
                step();
                t++;
            end
            if (!in_ready) begin
                chk($sformatf("in_ready_timeout_beat%0d", b), 0, 1);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input int f);
        chk($sformatf("f%0d_out_valid", f), out_valid, 1);
        chk($sformatf("f%0d_fill_level", f), fill_level, 16);
        chk($sformatf("f%0d_in_ready", f), in_ready, 0);
        foreach (tbl[i]) begin
            if (tbl[i].frame == f) begin
                chk($sformatf("f%0d_out[%0d][%0d]", f, tbl[i].row, tbl[i].col),
                    out[tbl[i].row][tbl[i].col], tbl[i].exp);
            end
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("handoff_out_valid", out_valid, 0);
        chk("handoff_in_ready", in_ready, 1);
    endtask

    initial begin
        // frame 0: banded, offset 0
        tbl.push_back('{0, 0, 0, 0});
        tbl.push_back('{0, 3, 0, 3});
        tbl.push_back('{0, 0, 1, 4});
        tbl.push_back('{0, 4, 0, 0});
        tbl.push_back('{0, 5, 0, 1});
        tbl.push_back('{0, 4, 1, 4});
        tbl.push_back('{0, 7, 7, 15});
        tbl.push_back('{0, 2, 3, 14});
        tbl.push_back('{0, 6, 2, 10});
        // frame 1: row-major, offset 0
        tbl.push_back('{1, 0, 1, 1});
        tbl.push_back('{1, 1, 0, 8});
        tbl.push_back('{1, 7, 7, 15});
        tbl.push_back('{1, 3, 5, 13});
        tbl.push_back('{1, 4, 0, 0});
        tbl.push_back('{1, 0, 4, 4});
        // frame 2: mode toggled mid-frame, still banded, offset 3
        tbl.push_back('{2, 0, 1, 7});
        tbl.push_back('{2, 1, 0, 4});
        tbl.push_back('{2, 7, 7, 2});
        tbl.push_back('{2, 4, 0, 3});
        // frame 3: row-major, offset 9
        tbl.push_back('{3, 0, 1, 10});
        tbl.push_back('{3, 1, 0, 1});
        tbl.push_back('{3, 7, 7, 8});
        tbl.push_back('{3, 0, 4, 13});
        // frame 4: banded after clear, offset 11
        tbl.push_back('{4, 0, 0, 11});
        tbl.push_back('{4, 3, 0, 14});
        tbl.push_back('{4, 0, 1, 15});
        tbl.push_back('{4, 5, 0, 12});
        tbl.push_back('{4, 7, 7, 10});

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fill_level", fill_level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out00", out[0][0], 0);
        chk("rst_out77", out[7][7], 0);

        send_beats(0, 16, 1'b0, 0, 1'b0);
        check_frame(0);
        handoff();

        send_beats(0, 16, 1'b1, 0, 1'b0);
        check_frame(1);

        // Downstream stall with upstream still offering a beat.
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
            chk($sformatf("stall%0d_out_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_out10", i), out[1][0], 8);
            step();
        end
        chk("stall_fill_level", fill_level, 16);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        chk("stall_release_in_ready_same", in_ready, 0);
        step();
        out_ready = 1'b0;
        #1;
        chk("stall_release_in_ready_next", in_ready, 1);
        chk("stall_release_out_valid", out_valid, 0);
        chk("stall_release_fill", fill_level, 0);
        chk("stall_release_retained", out[1][0], 8);

        send_beats(0, 16, 1'b0, 3, 1'b1);
        check_frame(2);
        handoff();

        send_beats(0, 16, 1'b1, 9, 1'b0);
        check_frame(3);
        handoff();

        // Abort a partial frame with clear while a beat is offered.
        send_beats(0, 7, 1'b0, 5, 1'b0);
        chk("pre_clear_fill", fill_level, 7);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        clear    = 1'b1;
        #1;
        chk("clear_in_ready", in_ready, 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_clear_fill", fill_level, 0);
        chk("post_clear_out_valid", out_valid, 0);
        send_beats(0, 15, 1'b0, 11, 1'b0);
        chk("after15_out_valid", out_valid, 0);
        chk("after15_fill", fill_level, 15);
        send_beats(15, 1, 1'b0, 11, 1'b0);
        check_frame(4);

        // Reset while holding a full frame.
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_full_out_valid", out_valid, 0);
        chk("rst_full_fill", fill_level, 0);
        chk("rst_full_in_ready", in_ready, 1);
        chk("rst_full_out00", out[0][0], 0);
        chk("rst_full_out77", out[7][7], 0);

        // Reset partway through a frame.
        send_beats(0, 5, 1'b1, 7, 1'b0);
        chk("mid_fill_level", fill_level, 5);
        chk("mid_out00", out[0][0], 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_fill", fill_level, 0);
        chk("rst_mid_out00", out[0][0], 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
